// File: rtl/cdc_src_arbiter.sv
// Round-robin arbiter sharing one CDC source port between NumReq requesters, with a
// clear sequencer that stops grants, drains the output slot and waits for CDC idle.
module cdc_src_arbiter #(
  parameter type         T        = logic,
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
  input  T                    req_data_i [NumReq],
  output logic                cdc_valid_o,
  input  logic                cdc_ready_i,
  output T                    cdc_data_o,
  output logic [IdxWidth-1:0] cdc_idx_o,
  input  logic                cdc_idle_i,
  input  logic                clear_req_i,
  output logic                clear_ack_o
);

  typedef logic [IdxWidth-1:0] idx_t;
  typedef enum logic [1:0] {StRun, StDrain, StCleared} state_e;

  state_e state_q;
  idx_t   rr_ptr_q;
  logic   cdc_valid_q;
  T       cdc_data_q;
  idx_t   cdc_idx_q;
  logic   clear_ack_q;

  idx_t   win_idx;
  idx_t   rr_ptr_inc;
  logic   win_found;
  logic   slot_free;
  logic   grant;

  // Scan requesters starting at rr_ptr_q, wrapping modulo NumReq.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!win_found && req_valid_i[idx_t'((32'(rr_ptr_q) + k) % NumReq)]) begin
        win_found = 1'b1;
        win_idx   = idx_t'((32'(rr_ptr_q) + k) % NumReq);
      end
    end
  end

  always_comb begin
    slot_free   = !cdc_valid_q || cdc_ready_i;
    grant       = !rst_i && (state_q == StRun) && !clear_req_i && slot_free && win_found;
    rr_ptr_inc  = (32'(win_idx) == NumReq - 1) ? '0 : win_idx + 1'b1;
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      rr_ptr_q    <= '0;
      cdc_valid_q <= 1'b0;
      cdc_data_q  <= '0;
      cdc_idx_q   <= '0;
      clear_ack_q <= 1'b0;
    end else begin
      // A grant refills the slot even when it drains on this same edge.
      if (grant) begin
        cdc_valid_q <= 1'b1;
        cdc_data_q  <= req_data_i[win_idx];
        cdc_idx_q   <= win_idx;
        rr_ptr_q    <= rr_ptr_inc;
      end else if (cdc_ready_i) begin
        cdc_valid_q <= 1'b0;
      end

      case (state_q)
        StRun: begin
          if (clear_req_i) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // Abort takes priority; a slot draining this cycle still counts as busy.
          if (!clear_req_i) begin
            state_q <= StRun;
          end else if (!cdc_valid_q && cdc_idle_i) begin
            state_q     <= StCleared;
            clear_ack_q <= 1'b1;
          end
        end
        StCleared: begin
          rr_ptr_q <= '0;
          if (!clear_req_i) begin
            state_q     <= StRun;
            clear_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign cdc_valid_o = cdc_valid_q;
  assign cdc_data_o  = cdc_data_q;
  assign cdc_idx_o   = cdc_idx_q;
  assign clear_ack_o = clear_ack_q;

endmodule

// File: tb/tb_cdc_src_arbiter.sv
// Directed bench for cdc_src_arbiter: expected grants are pushed to a scoreboard queue and a
// separate monitor pops and compares each CDC handshake.
module tb_cdc_src_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] req_data [4];
  logic       cdc_valid;
  logic       cdc_ready;
  logic [7:0] cdc_data;
  logic [1:0] cdc_idx;
  logic       cdc_idle;
  logic       clear_req;
  logic       clear_ack;

  logic [9:0] exp_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         pushed [4];
  int         popped [4];

  cdc_src_arbiter #(
    .T      (logic [7:0]),
    .NumReq (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .cdc_valid_o (cdc_valid),
    .cdc_ready_i (cdc_ready),
    .cdc_data_o  (cdc_data),
    .cdc_idx_o   (cdc_idx),
    .cdc_idle_i  (cdc_idle),
    .clear_req_i (clear_req),
    .clear_ack_o (clear_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Checks one cycle at the negedge, records the expected grant, then advances past the edge.
  task automatic step(input logic [3:0] exp_rdy, input logic exp_ack, input string tag);
    logic [1:0] ix;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    check({tag, ".ack"}, 32'(clear_ack), 32'(exp_ack));
    if (exp_rdy != 4'b0) begin
      ix = 2'd0;
      for (int i = 0; i < 4; i++) begin
        if (exp_rdy[i]) ix = 2'(i);
      end
      exp_q.push_back({ix, 8'hA4 + 8'(ix)});
      pushed[ix]++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && cdc_valid && cdc_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon.unexpected: got idx %0d data 0x%0h expected no item", cdc_idx, cdc_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("mon.idx", 32'(cdc_idx), 32'(e[9:8]));
        check("mon.data", 32'(cdc_data), 32'(e[7:0]));
        popped[cdc_idx]++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_data[i] = 8'hA4 + 8'(i);
      pushed[i]   = 0;
      popped[i]   = 0;
    end
    rst       = 1'b1;
    req_valid = 4'hF;
    cdc_ready = 1'b1;
    cdc_idle  = 1'b0;
    clear_req = 1'b0;

    // Reset state, with all requesters valid.
    step(4'b0000, 1'b0, "rst0");
    check("rst.valid", 32'(cdc_valid), 32'd0);
    check("rst.idx", 32'(cdc_idx), 32'd0);
    check("rst.data", 32'(cdc_data), 32'd0);
    step(4'b0000, 1'b0, "rst1");
    rst = 1'b0;

    // Full round robin 0,1,2,3,0 at one item per cycle.
    step(4'b0001, 1'b0, "rr0");
    check("rr0.valid", 32'(cdc_valid), 32'd1);
    step(4'b0010, 1'b0, "rr1");
    check("rr1.valid", 32'(cdc_valid), 32'd1);
    step(4'b0100, 1'b0, "rr2");
    step(4'b1000, 1'b0, "rr3");
    step(4'b0001, 1'b0, "rr4");
    check("rr4.valid", 32'(cdc_valid), 32'd1);

    // Move pointer to 2, then wrap-around with only 0 and 1 valid.
    req_valid = 4'b0010;
    step(4'b0010, 1'b0, "wrap_pre");
    req_valid = 4'b0011;
    step(4'b0001, 1'b0, "wrap0");
    step(4'b0010, 1'b0, "wrap1");

    // Backpressure: slot holds 0xA5 idx 1 while ready is low.
    req_valid = 4'hF;
    cdc_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(4'b0000, 1'b0, "bp");
      check("bp.data", 32'(cdc_data), 32'hA5);
      check("bp.idx", 32'(cdc_idx), 32'd1);
    end
    cdc_ready = 1'b1;
    step(4'b0100, 1'b0, "bp_refill");
    check("bp_refill.idx", 32'(cdc_idx), 32'd2);
    check("bp_refill.valid", 32'(cdc_valid), 32'd1);

    // Clear with slot full and CDC busy.
    clear_req = 1'b1;
    cdc_ready = 1'b0;
    step(4'b0000, 1'b0, "clr_run");
    step(4'b0000, 1'b0, "clr_hold");
    cdc_ready = 1'b1;
    step(4'b0000, 1'b0, "clr_drain");
    check("clr_drain.valid", 32'(cdc_valid), 32'd0);
    step(4'b0000, 1'b0, "clr_wait_idle");
    cdc_idle = 1'b1;
    step(4'b0000, 1'b0, "clr_idle");
    step(4'b0000, 1'b1, "clr_done");
    clear_req = 1'b0;
    step(4'b0000, 1'b1, "clr_release");
    step(4'b0001, 1'b0, "clr_first");

    // One-cycle clear pulse while the slot is full: abort back to RUN.
    cdc_ready = 1'b0;
    clear_req = 1'b1;
    step(4'b0000, 1'b0, "pulse");
    clear_req = 1'b0;
    cdc_ready = 1'b1;
    step(4'b0000, 1'b0, "pulse_abort");
    step(4'b0010, 1'b0, "pulse_resume1");
    step(4'b0100, 1'b0, "pulse_resume2");
    step(4'b1000, 1'b0, "pulse_resume3");

    // Reset mid-transfer: in-flight item is discarded.
    step(4'b0001, 1'b0, "mid_pre");
    rst = 1'b1;
    foreach (exp_q[i]) pushed[exp_q[i][9:8]]--;
    exp_q.delete();
    step(4'b0000, 1'b0, "mid_rst0");
    check("mid_rst0.valid", 32'(cdc_valid), 32'd0);
    check("mid_rst0.idx", 32'(cdc_idx), 32'd0);
    step(4'b0000, 1'b0, "mid_rst1");
    rst = 1'b0;
    step(4'b0001, 1'b0, "mid_first");
    step(4'b0010, 1'b0, "mid_second");
    req_valid = 4'b0000;
    step(4'b0000, 1'b0, "final_drain");
    step(4'b0000, 1'b0, "final_idle");

    check("sb.empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sb.count%0d", i), 32'(popped[i]), 32'(pushed[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
